// File: rtl/accum_engine.sv
// accum_engine: multi-channel accumulator fed by a valid/ready port.
// Each accepted sample waits DELAY cycles, then adds into its channel.
//
// Ports:
//   CLK, RST          clock, async active-high reset
//   in_valid/ready    sample handshake
//   in_chan/in_value  target channel, unsigned addend
//   clear             sync clear of accumulators, flags, in-flight work
//   rd_chan/rd_value  combinational read port (0 when out of range)
//   led               acc[0][LED_LSB +: 8]
//   overflow, err     sticky per-channel carry-out, bad-channel flag
//   busy              FSM not idle
module accum_engine #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DELAY    = 1,
  parameter int SATURATE = 0,
  parameter int LED_LSB  = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [WIDTH-1:0]    in_value,
  input  logic                clear,
  input  logic [CW-1:0]       rd_chan,
  output logic [WIDTH-1:0]    rd_value,
  output logic [7:0]          led,
  output logic [CHANNELS-1:0] overflow,
  output logic                err,
  output logic                busy
);

  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [DW-1:0] DLY_M1 =
    (DELAY > 0) ? DW'(DELAY - 1) : '0;
  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCUM
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DW-1:0]       r_cnt;
  logic [CW-1:0]       r_chan;
  logic [WIDTH-1:0]    r_val;
  logic [WIDTH-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic                r_err;

  logic                w_xfer;
  logic                w_hit;
  logic [WIDTH-1:0]    w_cur;
  logic [WIDTH-1:0]    w_rd;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_new;

  assign in_ready = (r_state == S_IDLE) && !clear;
  assign w_xfer   = in_valid && in_ready;
  assign w_hit    = {1'b0, r_chan} < CH_LIM;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_ovf;
  assign err      = r_err;
  assign led      = r_acc[0][LED_LSB +: 8];
  assign rd_value = w_rd;

  // Decoded muxes: an out-of-range index matches no channel, so the
  // read port naturally returns zero for it.
  always_comb begin
    w_cur = '0;
    w_rd  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_chan == CW'(i))  w_cur = r_acc[i];
      if (rd_chan == CW'(i)) w_rd  = r_acc[i];
    end
  end

  // One extra bit catches the carry-out used for overflow.
  assign w_sum = {1'b0, w_cur} + {1'b0, r_val};
  assign w_new = (SATURATE != 0 && w_sum[WIDTH]) ? '1
               : w_sum[WIDTH-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_xfer) w_next = (DELAY > 0) ? S_WAIT : S_ACCUM;
      S_WAIT:
        if (r_cnt == '0) w_next = S_ACCUM;
      S_ACCUM:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_xfer)
        r_cnt <= DLY_M1;
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - DW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_chan <= '0;
      r_val  <= '0;
    end else if (clear) begin
      r_chan <= '0;
      r_val  <= '0;
    end else if (w_xfer) begin
      r_chan <= in_chan;
      r_val  <= in_value;
    end
  end

  // clear takes priority over a coincident ACCUM write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      r_ovf <= '0;
      r_err <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      r_ovf <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_ACCUM) begin
      if (w_hit) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (r_chan == CW'(i)) begin
            r_acc[i] <= w_new;
            r_ovf[i] <= r_ovf[i] | w_sum[WIDTH];
          end
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accum_engine.sv
// tb_accum_engine: directed checks of accum_engine.
// DUT a: defaults; DUT b: CHANNELS=3, DELAY=0, SATURATE=1.
module tb_accum_engine;

  logic        clk;
  logic        rst;

  logic        a_valid;
  logic        a_ready;
  logic [1:0]  a_chan;
  logic [31:0] a_val;
  logic        a_clr;
  logic [1:0]  a_rd;
  logic [31:0] a_rdv;
  logic [7:0]  a_led;
  logic [3:0]  a_ovf;
  logic        a_err;
  logic        a_busy;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_chan;
  logic [31:0] b_val;
  logic        b_clr;
  logic [1:0]  b_rd;
  logic [31:0] b_rdv;
  logic [7:0]  b_led;
  logic [2:0]  b_ovf;
  logic        b_err;
  logic        b_busy;

  int n_chk;
  int n_err;

  accum_engine u_a (
    .CLK      (clk),
    .RST      (rst),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .in_chan  (a_chan),
    .in_value (a_val),
    .clear    (a_clr),
    .rd_chan  (a_rd),
    .rd_value (a_rdv),
    .led      (a_led),
    .overflow (a_ovf),
    .err      (a_err),
    .busy     (a_busy)
  );

  accum_engine #(
    .CHANNELS (3),
    .DELAY    (0),
    .SATURATE (1)
  ) u_b (
    .CLK      (clk),
    .RST      (rst),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .in_chan  (b_chan),
    .in_value (b_val),
    .clear    (b_clr),
    .rd_chan  (b_rd),
    .rd_value (b_rdv),
    .led      (b_led),
    .overflow (b_ovf),
    .err      (b_err),
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one sample on DUT a, then wait until its result is visible.
  task automatic send_a(input logic [1:0] ch, input logic [31:0] v);
    @(negedge clk);
    a_valid = 1'b1;
    a_chan  = ch;
    a_val   = v;
    chk("a_ready_pre", a_ready, 1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [1:0] ch, input logic [31:0] v);
    @(negedge clk);
    b_valid = 1'b1;
    b_chan  = ch;
    b_val   = v;
    chk("b_ready_pre", b_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b1;
    a_valid = 1'b0; a_chan = '0; a_val = '0; a_clr = 1'b0; a_rd = '0;
    b_valid = 1'b0; b_chan = '0; b_val = '0; b_clr = 1'b0; b_rd = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_busy",  a_busy, 0);
    chk("rst_led",   a_led, 0);
    chk("rst_rd",    a_rdv, 0);
    chk("rst_ovf",   a_ovf, 0);
    chk("rst_err",   a_err, 0);
    rst = 1'b0;

    // basic accept timing on channel 2
    a_rd = 2'd2;
    @(negedge clk);
    a_valid = 1'b1; a_chan = 2'd2; a_val = 32'd5;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    chk("basic_ready_e0", a_ready, 0);
    chk("basic_busy_e0",  a_busy, 1);
    chk("basic_acc_e0",   a_rdv, 0);
    @(posedge clk);
    @(negedge clk);
    chk("basic_ready_e1", a_ready, 0);
    chk("basic_acc_e1",   a_rdv, 0);
    @(posedge clk);
    @(negedge clk);
    chk("basic_ready_e2", a_ready, 1);
    chk("basic_acc_e2",   a_rdv, 5);
    send_a(2'd2, 32'd7);
    chk("basic_acc2", a_rdv, 12);

    // wrap on channel 1
    a_rd = 2'd1;
    send_a(2'd1, 32'hFFFF_FFF0);
    chk("wrap_pre",     a_rdv, 32'hFFFF_FFF0);
    chk("wrap_pre_ovf", a_ovf, 0);
    send_a(2'd1, 32'h20);
    chk("wrap_acc", a_rdv, 32'h10);
    chk("wrap_ovf", a_ovf, 4'b0010);

    // LED window
    send_a(2'd0, 32'h00AB_0000);
    chk("led", a_led, 8'hAB);
    a_rd = 2'd2;
    @(negedge clk);
    chk("ch2_keep", a_rdv, 12);

    // async reset during WAIT
    a_rd = 2'd3;
    @(negedge clk);
    a_valid = 1'b1; a_chan = 2'd3; a_val = 32'h100;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    chk("rmid_busy_pre", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("rmid_busy", a_busy, 0);
    chk("rmid_ready", a_ready, 1);
    chk("rmid_led", a_led, 0);
    chk("rmid_ovf", a_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rmid_acc3", a_rdv, 0);
    chk("rmid_busy_post", a_busy, 0);

    // clear during WAIT
    a_rd = 2'd1;
    send_a(2'd1, 32'd3);
    chk("clr_pre_acc1", a_rdv, 3);
    @(negedge clk);
    a_valid = 1'b1; a_chan = 2'd0; a_val = 32'd9;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    a_clr   = 1'b1;
    #1;
    chk("clr_ready", a_ready, 0);
    @(posedge clk);
    @(negedge clk);
    a_clr = 1'b0;
    chk("clr_busy", a_busy, 0);
    chk("clr_acc1", a_rdv, 0);
    a_rd = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("clr_acc0", a_rdv, 0);
    chk("clr_ready_post", a_ready, 1);

    // DUT b: DELAY=0 back-to-back, six accepts in 12 edges
    b_rd = 2'd0;
    @(negedge clk);
    b_valid = 1'b1; b_chan = 2'd0; b_val = 32'd1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 10) b_valid = 1'b0;
    end
    chk("d0_acc", b_rdv, 6);
    chk("d0_busy", b_busy, 0);

    // saturate on channel 1
    b_rd = 2'd1;
    send_b(2'd1, 32'hFFFF_FFF0);
    send_b(2'd1, 32'h20);
    chk("sat_acc", b_rdv, 32'hFFFF_FFFF);
    chk("sat_ovf", b_ovf, 3'b010);

    // out-of-range channel on a 3-channel build
    send_b(2'd3, 32'd5);
    chk("rng_err", b_err, 1);
    chk("rng_ovf", b_ovf, 3'b010);
    chk("rng_acc1", b_rdv, 32'hFFFF_FFFF);
    b_rd = 2'd0;
    @(negedge clk);
    chk("rng_acc0", b_rdv, 6);
    b_rd = 2'd2;
    @(negedge clk);
    chk("rng_acc2", b_rdv, 0);
    b_rd = 2'd3;
    @(negedge clk);
    chk("rng_rd3", b_rdv, 0);
    chk("rng_ready", b_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
